alu_exec_unit: RTL and testbench

- Parametrised successor to the combinational ALU control decoder: decodes ALU_op/FuncCode and executes the operation on registered operands.
- Single-cycle ops return in 1 clock.
- MULTU runs as a WIDTH-cycle shift-add sequence into HI/LO registers, with a valid/ready handshake.
- Sits between the register-file read stage and the writeback stage of the multicycle MIPS datapath.

---
 rtl/alu_exec_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execution ALU: decodes ALU_op/FuncCode, returns single-cycle ops in one clock and runs
// MULTU as a WIDTH-cycle shift-add into HI/LO. Optional restoring DIVU under `ALU_DIVU_EN.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic [1:0]       ALU_op,
  input  logic [5:0]       FuncCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Illegal,
  output logic [3:0]       ALU_Ctl,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [3:0] {
    CTL_AND     = 4'b0000,
    CTL_OR      = 4'b0001,
    CTL_ADD     = 4'b0010,
    CTL_SUB     = 4'b0110,
    CTL_SLT     = 4'b0111,
    CTL_NOR     = 4'b1100,
    CTL_MULTU   = 4'b1000,
`ifdef ALU_DIVU_EN
    CTL_DIVU    = 4'b1001,
`endif
    CTL_MFHI    = 4'b1010,
    CTL_MFLO    = 4'b1011,
    CTL_ILLEGAL = 4'b1111
  } ctl_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
`ifdef ALU_DIVU_EN
    , S_DIV = 2'd3
`endif
  } state_e;

  state_e               state_q, state_d;
  ctl_e                 ctl_q, ctl_d;
  ctl_e                 dec_ctl;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 illegal_q, illegal_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     alu_res;
  logic [WIDTH:0]       mul_sum;
`ifdef ALU_DIVU_EN
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_rem;
  logic                 div_qbit;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dec_ctl = CTL_ADD;
    if (ALU_op == 2'b10) begin
      unique case (FuncCode)
        6'b100000: dec_ctl = CTL_ADD;
        6'b100010: dec_ctl = CTL_SUB;
        6'b100100: dec_ctl = CTL_AND;
        6'b100101: dec_ctl = CTL_OR;
        6'b101010: dec_ctl = CTL_SLT;
        6'b100111: dec_ctl = CTL_NOR;
        6'b011001: dec_ctl = CTL_MULTU;
`ifdef ALU_DIVU_EN
        6'b011011: dec_ctl = CTL_DIVU;
`endif
        6'b010000: dec_ctl = CTL_MFHI;
        6'b010010: dec_ctl = CTL_MFLO;
        default:   dec_ctl = CTL_ILLEGAL;
      endcase
    end else if (ALU_op[0]) begin
      dec_ctl = CTL_SUB;
    end
  end

  always_comb begin
    alu_res = '0;
    case (dec_ctl)
      CTL_ADD:  alu_res = A + B;
      CTL_SUB:  alu_res = A - B;
      CTL_AND:  alu_res = A & B;
      CTL_OR:   alu_res = A | B;
      CTL_NOR:  alu_res = ~(A | B);
      CTL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      CTL_MFHI: alu_res = hi_q;
      CTL_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ctl_d     = ctl_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    valid_d   = 1'b0;

    // Accumulator upper half plus the gated multiplicand, carry kept in the extra bit.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
`ifdef ALU_DIVU_EN
    // acc_q holds {remainder, dividend/quotient}; shift one dividend bit into the remainder.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_qbit  = (div_shift >= {1'b0, mcand_q});
    div_rem   = div_qbit ? (div_shift - {1'b0, mcand_q}) : div_shift;
`endif

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          ctl_d = dec_ctl;
          if (dec_ctl == CTL_MULTU) begin
            mcand_d  = A;
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
`ifdef ALU_DIVU_EN
          end else if (dec_ctl == CTL_DIVU) begin
            mcand_d = B;
            acc_d   = {{WIDTH{1'b0}}, A};
            cnt_d   = '0;
            state_d = S_DIV;
`endif
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = (dec_ctl == CTL_ILLEGAL);
            valid_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = {mul_sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_DONE;
      end
`ifdef ALU_DIVU_EN
      S_DIV: begin
        acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        hi_d      = acc_q[2*WIDTH-1:WIDTH];
        lo_d      = acc_q[WIDTH-1:0];
        result_d  = acc_q[WIDTH-1:0];
        zero_d    = (acc_q[WIDTH-1:0] == '0);
        illegal_d = 1'b0;
        valid_d   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ctl_q     <= CTL_AND;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      valid_q   <= valid_d;
    end
  end

  assign ready_out = (state_q == S_IDLE);
  assign valid_out = valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Illegal   = illegal_q;
  assign ALU_Ctl   = ctl_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, directed multi-cycle sequences,
// and randomized ops compared against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         valid_in = 1'b0;
  logic [1:0]   alu_op = '0;
  logic [5:0]   func = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready_out, valid_out, zero, illegal;
  logic [W-1:0] result, hi, lo;
  logic [3:0]   alu_ctl;

  int total = 0;
  int bad = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  alu_exec_unit #(.WIDTH(W)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .valid_in (valid_in),
    .ALU_op   (alu_op),
    .FuncCode (func),
    .A        (a),
    .B        (b),
    .ready_out(ready_out),
    .valid_out(valid_out),
    .Result   (result),
    .Zero     (zero),
    .Illegal  (illegal),
    .ALU_Ctl  (alu_ctl),
    .HI       (hi),
    .LO       (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   ctl;
    logic         ill;
    int           lat;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  // Expected outcome from the instruction semantics; lat = clock edges after the accepting edge.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [W-1:0] cur_hi, input logic [W-1:0] cur_lo);
    exp_t e;
    logic [2*W-1:0] p;
    e.hi = cur_hi; e.lo = cur_lo; e.ill = 1'b0; e.lat = 0; e.res = '0;
    if (op == 2'b00)   e.ctl = 4'b0010;
    else if (op[0])    e.ctl = 4'b0110;
    else begin
      case (f)
        6'h20: e.ctl = 4'b0010;
        6'h22: e.ctl = 4'b0110;
        6'h24: e.ctl = 4'b0000;
        6'h25: e.ctl = 4'b0001;
        6'h2a: e.ctl = 4'b0111;
        6'h27: e.ctl = 4'b1100;
        6'h19: e.ctl = 4'b1000;
        6'h10: e.ctl = 4'b1010;
        6'h12: e.ctl = 4'b1011;
`ifdef ALU_DIVU_EN
        6'h1b: e.ctl = 4'b1001;
`endif
        default: e.ctl = 4'b1111;
      endcase
    end
    case (e.ctl)
      4'b0010: e.res = x + y;
      4'b0110: e.res = x - y;
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b1100: e.res = ~(x | y);
      4'b0111: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      4'b1010: e.res = cur_hi;
      4'b1011: e.res = cur_lo;
      4'b1000: begin
        p = (2*W)'(x) * (2*W)'(y);
        e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; e.res = e.lo; e.lat = W + 1;
      end
      4'b1001: begin
        if (y == '0) begin e.lo = '1; e.hi = x; end
        else begin e.lo = x / y; e.hi = x % y; end
        e.res = e.lo; e.lat = W + 1;
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Presents one op (caller is #1 after an edge with ready_out=1) and checks its completion.
  task automatic run_op(input logic [1:0] op, input logic [5:0] f,
                        input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    exp_t e;
    int n;
    e = model(op, f, x, y, m_hi, m_lo);
    alu_op = op; func = f; a = x; b = y; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    n = 0;
    while (!valid_out && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("%s.latency", tag), 64'(n), 64'(e.lat));
    check($sformatf("%s.result", tag), 64'(result), 64'(e.res));
    check($sformatf("%s.zero", tag), 64'(zero), 64'(e.res == '0));
    check($sformatf("%s.illegal", tag), 64'(illegal), 64'(e.ill));
    check($sformatf("%s.ctl", tag), 64'(alu_ctl), 64'(e.ctl));
    check($sformatf("%s.hi", tag), 64'(hi), 64'(e.hi));
    check($sformatf("%s.lo", tag), 64'(lo), 64'(e.lo));
    m_hi = e.hi; m_lo = e.lo;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [5:0]   f;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] res;
    logic [3:0]   ctl;
    logic         ill;
  } vec_t;

  vec_t tbl[11];
  logic [5:0] funct_pool[10];

  initial begin
    int lowcnt, n;
    logic [5:0] rf;
    logic [1:0] rop;

    tbl[0]  = '{2'b10, 6'h20, 32'h0000000C, 32'h0000000A, 32'h00000016, 4'b0010, 1'b0};
    tbl[1]  = '{2'b10, 6'h22, 32'h0000000C, 32'h0000000A, 32'h00000002, 4'b0110, 1'b0};
    tbl[2]  = '{2'b10, 6'h24, 32'h0000000C, 32'h0000000A, 32'h00000008, 4'b0000, 1'b0};
    tbl[3]  = '{2'b10, 6'h25, 32'h0000000C, 32'h0000000A, 32'h0000000E, 4'b0001, 1'b0};
    tbl[4]  = '{2'b10, 6'h2a, 32'h0000000C, 32'h0000000A, 32'h00000000, 4'b0111, 1'b0};
    tbl[5]  = '{2'b10, 6'h27, 32'h0000000C, 32'h0000000A, 32'hFFFFFFF1, 4'b1100, 1'b0};
    tbl[6]  = '{2'b00, 6'h3f, 32'h00000005, 32'h00000003, 32'h00000008, 4'b0010, 1'b0};
    tbl[7]  = '{2'b01, 6'h20, 32'h00000007, 32'h00000007, 32'h00000000, 4'b0110, 1'b0};
    tbl[8]  = '{2'b11, 6'h24, 32'h00000007, 32'h00000007, 32'h00000000, 4'b0110, 1'b0};
    tbl[9]  = '{2'b10, 6'h3f, 32'h0000000C, 32'h0000000A, 32'h00000000, 4'b1111, 1'b1};
`ifdef ALU_DIVU_EN
    tbl[10] = '{2'b10, 6'h2a, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0111, 1'b0};
`else
    tbl[10] = '{2'b10, 6'h1b, 32'h00000064, 32'h00000007, 32'h00000000, 4'b1111, 1'b1};
`endif
    funct_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h19, 6'h10, 6'h12, 6'h1b};

    // Reset state
    #12;
    check("rst.ready", 64'(ready_out), 64'd1);
    check("rst.valid", 64'(valid_out), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.zero", 64'(zero), 64'd1);
    check("rst.illegal", 64'(illegal), 64'd0);
    check("rst.ctl", 64'(alu_ctl), 64'd0);
    check("rst.hi", 64'(hi), 64'd0);
    check("rst.lo", 64'(lo), 64'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back single-cycle vectors
    for (int i = 0; i < 11; i++) begin
      alu_op = tbl[i].op; func = tbl[i].f; a = tbl[i].x; b = tbl[i].y; valid_in = 1'b1;
      @(posedge clk); #1;
      check($sformatf("vec%0d.valid", i), 64'(valid_out), 64'd1);
      check($sformatf("vec%0d.result", i), 64'(result), 64'(tbl[i].res));
      check($sformatf("vec%0d.zero", i), 64'(zero), 64'(tbl[i].res == '0));
      check($sformatf("vec%0d.illegal", i), 64'(illegal), 64'(tbl[i].ill));
      check($sformatf("vec%0d.ctl", i), 64'(alu_ctl), 64'(tbl[i].ctl));
    end
    valid_in = 1'b0;
    @(posedge clk); #1;
    check("idle.valid_low", 64'(valid_out), 64'd0);

    // MULTU 0xFFFFFFFF * 2 with ignored requests during the multiply
    alu_op = 2'b10; func = 6'h19; a = 32'hFFFFFFFF; b = 32'h00000002; valid_in = 1'b1;
    @(posedge clk); #1;
    n = 0; lowcnt = 0;
    while (!valid_out && n < 200) begin
      if (!ready_out) lowcnt++;
      alu_op = 2'b00; a = 32'h1; b = 32'h1; valid_in = n[0];
      @(posedge clk); #1;
      n++;
    end
    valid_in = 1'b0;
    check("mul.latency", 64'(n), 64'(W + 1));
    check("mul.ready_low_cycles", 64'(lowcnt), 64'(W + 1));
    check("mul.ready_after", 64'(ready_out), 64'd1);
    check("mul.hi", 64'(hi), 64'h00000001);
    check("mul.lo", 64'(lo), 64'hFFFFFFFE);
    check("mul.result", 64'(result), 64'hFFFFFFFE);
    check("mul.ctl", 64'(alu_ctl), 64'b1000);
    @(posedge clk); #1;
    check("mul.single_pulse", 64'(valid_out), 64'd0);
    m_hi = 32'h00000001; m_lo = 32'hFFFFFFFE;

    run_op(2'b10, 6'h10, 32'h0, 32'h0, "mfhi");
    run_op(2'b10, 6'h12, 32'h0, 32'h0, "mflo");
    run_op(2'b10, 6'h3f, 32'h12345678, 32'h9ABCDEF0, "illegal_keeps_hilo");

`ifdef ALU_DIVU_EN
    run_op(2'b10, 6'h1b, 32'd100, 32'd7, "divu_100_7");
    check("divu_100_7.lo_lit", 64'(lo), 64'd14);
    check("divu_100_7.hi_lit", 64'(hi), 64'd2);
    run_op(2'b10, 6'h1b, 32'd5, 32'd0, "divu_by_zero");
    check("divu_by_zero.lo_lit", 64'(lo), 64'hFFFFFFFF);
    check("divu_by_zero.hi_lit", 64'(hi), 64'd5);
`endif

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      rop = ($urandom_range(0, 5) > 3) ? 2'b10 : 2'($urandom_range(0, 3));
      rf  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : funct_pool[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) == 0) run_op(rop, rf, W'($urandom_range(0, 3)), W'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
      else                           run_op(rop, rf, W'($urandom), W'($urandom), $sformatf("rnd%0d", i));
    end

    // Make HI/LO non-zero, then reset in the middle of a multiply
    run_op(2'b10, 6'h19, 32'hDEADBEEF, 32'h0000F00D, "pre_reset_mul");
    alu_op = 2'b10; func = 6'h19; a = 32'h12345; b = 32'h6789; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst.ready", 64'(ready_out), 64'd1);
    check("midrst.valid", 64'(valid_out), 64'd0);
    check("midrst.result", 64'(result), 64'd0);
    check("midrst.zero", 64'(zero), 64'd1);
    check("midrst.hi", 64'(hi), 64'd0);
    check("midrst.lo", 64'(lo), 64'd0);
    check("midrst.ctl", 64'(alu_ctl), 64'd0);
    #10 reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    run_op(2'b10, 6'h10, 32'h0, 32'h0, "post_rst_mfhi");
    run_op(2'b10, 6'h19, 32'h0000FFFF, 32'h0000FFFF, "post_rst_mul");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
